perf_event_counters: RTL
========================

Name: perf_event_counters

Overview:
- Synthesizable, parametrised statistics block for the 16-bit pipelined CPU. It replaces the bench-only instruction, cache-hit and cache-request counters with a bank of NUM_EVENTS event counters plus a free-running cycle counter.
- Counting freezes when halt is seen.
- A cycle-limit watchdog is included.
- Counters are read through a registered request/valid port by the bench or a debug unit.

Parameters:
- NUM_EVENTS, 4, number of event channels (index 0..NUM_EVENTS-1).
- CNT_W, 32, width of every counter, including the cycle counter.
- SAT_MODE, 1, 1 = counters saturate at all-ones; 0 = counters wrap to 0.
- QUAL_MASK, 4'b0011, bit k = 1 means event k is counted only when stall_i = 0.
- WDOG_LIMIT, 100000, cycle-count value that trips the watchdog; 0 disables the watchdog.

Ports:
- clk, input, 1, clock.
- rst_n, input, 1, synchronous active-low reset.
- enable_i, input, 1, level; starts counting from IDLE and gates counting while in RUN.
- event_i, input, NUM_EVENTS, per-channel event pulses; one increment per high cycle.
- stall_i, input, 1, pipeline stall (ISTALL | DSTALL); qualifies the channels selected by QUAL_MASK.
- halt_i, input, 1, halt reached writeback.
- clear_i, input, 1, zeroes all counters and flags and returns to IDLE.
- rd_req_i, input, 1, read request.
- rd_idx_i, input, IDX_W = $clog2(NUM_EVENTS+1), counter select; index NUM_EVENTS selects the cycle counter.
- rd_valid_o, output, 1, read data valid.
- rd_data_o, output, CNT_W, read data.
- ovf_o, output, NUM_EVENTS+1, sticky per-counter overflow/saturation flags; MSB belongs to the cycle counter.
- frozen_o, output, 1, high in FROZEN.
- wdog_o, output, 1, sticky watchdog trip.

Behaviour:
- Reset (rst_n = 0 at a clk edge):
  - state = IDLE.
  - All counters = 0.
  - ovf_o, wdog_o, frozen_o, rd_valid_o and rd_data_o = 0.
- States:
  - IDLE: no counting. Goes to RUN on the edge where enable_i = 1; that cycle's events are not counted.
  - RUN:
    - Each edge with enable_i = 1 increments the cycle counter by 1.
    - Event k increments iff event_i[k] & ~(QUAL_MASK[k] & stall_i).
    - With enable_i = 0, all counters hold.
  - FROZEN: all counters hold; frozen_o = 1. Leaves only via clear_i or reset.
- RUN to FROZEN on halt: on the edge where halt_i = 1 and enable_i = 1, that cycle's qualified events and the cycle increment are still counted, then state = FROZEN.
- Watchdog (WDOG_LIMIT != 0): in RUN, when the cycle counter's next value equals WDOG_LIMIT, the update is applied, wdog_o is set and state becomes FROZEN.
- Increment at all-ones:
  - SAT_MODE = 1: the counter holds all-ones and its ovf bit is set.
  - SAT_MODE = 0: the counter becomes 0 and its ovf bit is set.
  - ovf bits are sticky until clear_i or reset.
- Priority, highest first: reset, clear_i, halt/watchdog, increment.
- clear_i: on the edge it is seen, all counters and flags go to 0 and state goes to IDLE, in any state. Simultaneous clear_i and halt_i means clear wins.
- Read port:
  - A request sampled at edge N gives rd_valid_o = 1 for exactly one cycle after edge N. rd_data_o is the value the counter held before edge N, i.e. the pre-increment value.
  - rd_idx_i > NUM_EVENTS returns 0 with rd_valid_o = 1.
  - Back-to-back requests are accepted every cycle (latency 1, throughput 1).
  - rd_data_o holds its last value when rd_valid_o = 0.
  - clear_i on the same edge as rd_req_i returns the pre-clear value.
  - Reset drops rd_valid_o.
- Width: counters are unsigned CNT_W. WDOG_LIMIT is compared at CNT_W bits; a limit that does not fit in CNT_W is a compile-time error (assertion).

Decomposition:
- Shared package perf_pkg holds:
  - the state enum (IDLE, RUN, FROZEN);
  - the IDX_W function;
  - the CYCLE_IDX = NUM_EVENTS convention;
  - default QUAL_MASK constants for the CPU (bit0 = RegWrite/MemWrite retire, bit1 = DCacheReq, bit2 = ICacheHit, bit3 = DCacheHit).
- One sub-module, perf_counter_cell: single CNT_W counter with inc, clr and SAT_MODE, producing value and ovf. Instantiated NUM_EVENTS+1 times.
- The top level holds the FSM, watchdog and read mux.

Test Plan:
- Run/read: reset, enable_i = 1, pulse event_i[0] on 5 of 10 cycles with stall_i = 0 → reading index 0 gives 5 and index 4 (cycle counter) gives 10, each with rd_valid_o one cycle after rd_req_i.
- Stall qualification: event_i = 4'b1111 and stall_i = 1 for 3 cycles → counters 0 and 1 unchanged, counters 2 and 3 increase by 3, cycle counter increases by 3.
- Halt freeze: halt_i together with event_i[0] → that event is counted, frozen_o = 1 next cycle; 20 further event_i cycles leave all counters unchanged.
- Saturate/wrap: CNT_W = 4, counter preloaded to 15 via 15 events, then one more event → SAT_MODE = 1 reads 15 with ovf_o[0] = 1; SAT_MODE = 0 reads 0 with ovf_o[0] = 1.
- Watchdog: WDOG_LIMIT = 8, enable with no halt → after the 8th RUN cycle wdog_o = 1, frozen_o = 1 and the cycle counter reads 8.
- Clear priority: clear_i and halt_i on the same edge during RUN → all counters = 0, ovf_o = 0, state IDLE (frozen_o = 0); rd_idx_i = 7 returns 0 with rd_valid_o = 1.

Source files
------------

// File: rtl/perf_pkg.sv
// Shared types and constants for the CPU performance counter block.
// Channel index NUM_EVENTS is the free-running cycle counter.
package perf_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FROZEN
  } state_e;

  function automatic int idx_w(input int n);
    return $clog2(n + 1);
  endfunction

  function automatic int cycle_idx(input int n);
    return n;
  endfunction

  // Default stall qualification for the CPU event wiring
  localparam logic [3:0] QM_RETIRE = 4'b0001;
  localparam logic [3:0] QM_DREQ   = 4'b0010;
  localparam logic [3:0] QM_IHIT   = 4'b0100;
  localparam logic [3:0] QM_DHIT   = 4'b1000;
  localparam logic [3:0] QUAL_MASK_CPU = QM_RETIRE | QM_DREQ;

endpackage

// File: rtl/perf_counter_cell.sv
// One unsigned event counter with clear, saturate-or-wrap
// increment and a sticky overflow flag.
module perf_counter_cell #(
  parameter int CNT_W    = 32,
  parameter bit SAT_MODE = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clr,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_value,
  output logic             o_ovf
);

  logic [CNT_W-1:0] r_value;
  logic             r_ovf;
  logic             w_full;

  assign w_full = &r_value;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_value <= '0;
      r_ovf   <= 1'b0;
    end else if (i_clr) begin
      r_value <= '0;
      r_ovf   <= 1'b0;
    end else if (i_inc) begin
      if (w_full) begin
        r_value <= SAT_MODE ? r_value : '0;
        r_ovf   <= 1'b1;
      end else begin
        r_value <= r_value + 1'b1;
      end
    end
  end

  assign o_value = r_value;
  assign o_ovf   = r_ovf;

endmodule

// File: rtl/perf_event_counters.sv
// Event counter bank plus cycle counter with halt freeze,
// cycle-limit watchdog and a registered read port.
module perf_event_counters
  import perf_pkg::*;
#(
  parameter int                    NUM_EVENTS = 4,
  parameter int                    CNT_W      = 32,
  parameter bit                    SAT_MODE   = 1'b1,
  parameter logic [NUM_EVENTS-1:0] QUAL_MASK  = NUM_EVENTS'(QUAL_MASK_CPU),
  parameter int                    WDOG_LIMIT = 100000,
  parameter int                    IDX_W      = idx_w(NUM_EVENTS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable_i,
  input  logic [NUM_EVENTS-1:0] event_i,
  input  logic                  stall_i,
  input  logic                  halt_i,
  input  logic                  clear_i,
  input  logic                  rd_req_i,
  input  logic [IDX_W-1:0]      rd_idx_i,
  output logic                  rd_valid_o,
  output logic [CNT_W-1:0]      rd_data_o,
  output logic [NUM_EVENTS:0]   ovf_o,
  output logic                  frozen_o,
  output logic                  wdog_o
);

  localparam int CYC = cycle_idx(NUM_EVENTS);
  localparam logic [CNT_W-1:0] WDOG_CMP = CNT_W'(WDOG_LIMIT);

  if (WDOG_LIMIT < 0 ||
      (CNT_W < 31 && WDOG_LIMIT >= (1 << CNT_W))) begin : g_bad_limit
    $error("WDOG_LIMIT does not fit in CNT_W bits");
  end

  state_e r_state;
  state_e w_state_nxt;
  logic   r_wdog;
  logic   r_rd_valid;
  logic [CNT_W-1:0] r_rd_data;

  logic [NUM_EVENTS:0][CNT_W-1:0] w_val;
  logic [NUM_EVENTS:0]            w_inc;
  logic [CNT_W-1:0]               w_cyc_nxt;
  logic [CNT_W-1:0]               w_rd_mux;
  logic                           w_run_en;
  logic                           w_wdog_hit;

  assign w_run_en = (r_state == RUN) & enable_i & ~clear_i;

  assign w_inc[NUM_EVENTS-1:0] =
    {NUM_EVENTS{w_run_en}} & event_i & ~(QUAL_MASK & {NUM_EVENTS{stall_i}});
  assign w_inc[CYC] = w_run_en;

  for (genvar k = 0; k <= NUM_EVENTS; k++) begin : g_cell
    perf_counter_cell #(
      .CNT_W    (CNT_W),
      .SAT_MODE (SAT_MODE)
    ) u_cell (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_clr   (clear_i),
      .i_inc   (w_inc[k]),
      .o_value (w_val[k]),
      .o_ovf   (ovf_o[k])
    );
  end

  // Mirror the cell's increment so the limit is caught on the update edge
  assign w_cyc_nxt = (&w_val[CYC]) ?
                     (SAT_MODE ? w_val[CYC] : '0) :
                     w_val[CYC] + 1'b1;

  assign w_wdog_hit = (WDOG_LIMIT != 0) & w_run_en &
                      (w_cyc_nxt == WDOG_CMP);

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (enable_i) w_state_nxt = RUN;
      RUN:     if (halt_i || w_wdog_hit) w_state_nxt = FROZEN;
      FROZEN:  w_state_nxt = FROZEN;
      default: w_state_nxt = IDLE;
    endcase
    if (clear_i) w_state_nxt = IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_wdog  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (clear_i) r_wdog <= 1'b0;
      else if (w_wdog_hit) r_wdog <= 1'b1;
    end
  end

  always_comb begin
    w_rd_mux = '0;
    for (int k = 0; k <= NUM_EVENTS; k++) begin
      if (rd_idx_i == IDX_W'(k)) w_rd_mux = w_val[k];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
    end else begin
      r_rd_valid <= rd_req_i;
      if (rd_req_i) r_rd_data <= w_rd_mux;
    end
  end

  assign rd_valid_o = r_rd_valid;
  assign rd_data_o  = r_rd_data;
  assign frozen_o   = (r_state == FROZEN);
  assign wdog_o     = r_wdog;

endmodule
